// File: rtl/ring_osc_trim_ctrl.sv
// ring_osc_trim_ctrl: closed-loop thermometer trim of a 13-stage ring oscillator
module ring_osc_trim_ctrl #(
    parameter int WINDOW     = 1024,
    parameter int SETTLE     = 16,
    parameter int RST_CYCLES = 8,
    parameter int CNT_W      = 16,
    parameter int MAX_ITER   = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic             start,
    input  logic             osc_div_sync,
    input  logic [CNT_W-1:0] target,
    input  logic [CNT_W-1:0] tol,
    input  logic             manual_en,
    input  logic [4:0]       manual_code,
    output logic [25:0]      trim,
    output logic             osc_reset,
    output logic             busy,
    output logic             locked,
    output logic             done,
    output logic             err,
    output logic [4:0]       code
);
    typedef enum logic [2:0] {IDLE, ORST, SETL, MEAS, CMP, FIN} state_t;
    localparam int TW = $clog2(WINDOW + SETTLE + RST_CYCLES + 1);
    localparam int IW = $clog2(MAX_ITER + 1);
    localparam logic [TW-1:0] RST_LAST = TW'(RST_CYCLES - 1);
    localparam logic [TW-1:0] SET_LAST = TW'(SETTLE - 1);
    localparam logic [TW-1:0] WIN_LAST = TW'(WINDOW - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(MAX_ITER - 1);
    state_t state, state_nxt;
    logic [TW-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic [IW-1:0] iter;
    logic prev_s, dir, dir_vld;
    logic [CNT_W:0] hi, lo;
    logic up, dn, fin_lock, fin_err, step, abort, go;
    logic [4:0] code_nxt;
    assign hi = {1'b0, target} + {1'b0, tol};
    assign lo = target > tol ? {1'b0, target - tol} : '0;
    assign up = {1'b0, cnt} > hi;
    assign dn = {1'b0, cnt} < lo;
    assign abort = state != IDLE && !enable;
    assign go = state == IDLE && state_nxt == ORST;
    always_comb begin
        state_nxt = state;
        code_nxt = code;
        fin_lock = 1'b0;
        fin_err = 1'b0;
        step = 1'b0;
        if (abort) state_nxt = IDLE;
        else case (state)
            IDLE: begin
                if (manual_en) code_nxt = manual_code > 5'd26 ? 5'd26 : manual_code;
                else if (start && enable) state_nxt = ORST;
            end
            ORST: if (tmr == RST_LAST) state_nxt = SETL;
            SETL: if (tmr == SET_LAST) state_nxt = MEAS;
            MEAS: if (tmr == WIN_LAST) state_nxt = CMP;
            CMP: begin
                state_nxt = FIN;
                if (!up && !dn) fin_lock = 1'b1;
                else if ((up && code == 5'd26) || (dn && code == 5'd0)) fin_err = 1'b1;
                // a reversal means the target sits between two codes; keep the current one
                else if (dir_vld && dir != up) fin_lock = 1'b1;
                else if (iter == ITER_LAST) fin_err = 1'b1;
                else begin
                    step = 1'b1;
                    state_nxt = SETL;
                    code_nxt = up ? code + 5'd1 : code - 5'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            tmr       <= '0;
            cnt       <= '0;
            iter      <= '0;
            prev_s    <= 1'b0;
            dir       <= 1'b0;
            dir_vld   <= 1'b0;
            code      <= '0;
            trim      <= '0;
            osc_reset <= 1'b1;
            busy      <= 1'b0;
            locked    <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state  <= state_nxt;
            prev_s <= osc_div_sync;
            tmr    <= state_nxt != state ? '0 : tmr + 1'b1;
            if (state != MEAS) cnt <= '0;
            else if (osc_div_sync && !prev_s && cnt != '1) cnt <= cnt + 1'b1;
            if (go) begin
                iter    <= '0;
                dir_vld <= 1'b0;
            end else if (step) begin
                iter    <= iter + 1'b1;
                dir     <= up;
                dir_vld <= 1'b1;
            end
            code      <= code_nxt;
            trim      <= 26'((27'd1 << code_nxt) - 27'd1);
            osc_reset <= state_nxt == ORST || (state_nxt == IDLE && !manual_en && (!enable || osc_reset));
            busy      <= state_nxt inside {ORST, SETL, MEAS, CMP};
            done      <= fin_lock || fin_err;
            locked    <= fin_lock || (locked && !abort && !go);
            err       <= fin_err || (err && !go);
        end
    end
endmodule

// File: tb/tb_ring_osc_trim_ctrl.sv
// tb_ring_osc_trim_ctrl: scoreboard bench driving a trim-dependent oscillator model
module tb_ring_osc_trim_ctrl;
    typedef struct {
        logic [4:0]  code;
        logic        lk;
        logic        er;
        logic [25:0] trim;
        int          lat;
    } exp_t;
    logic clk = 0, resetn = 0, enable = 1, start = 0, osc_div_sync = 0, manual_en = 0;
    logic [15:0] target = 0, tol = 0;
    logic [4:0] manual_code = 0;
    logic [25:0] trim;
    logic osc_reset, busy, locked, done, err;
    logic [4:0] code;
    int cyc = 0, n_vec = 0, n_mis = 0, dones = 0, st_cyc = 0, mode = 0;
    exp_t exp_q[$];

    ring_osc_trim_ctrl dut (
        .clk(clk), .resetn(resetn), .enable(enable), .start(start),
        .osc_div_sync(osc_div_sync), .target(target), .tol(tol),
        .manual_en(manual_en), .manual_code(manual_code), .trim(trim),
        .osc_reset(osc_reset), .busy(busy), .locked(locked), .done(done),
        .err(err), .code(code)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // edges per 1024-cycle window as a function of the trim code
    function automatic int model(int k);
        case (mode)
            0: return 505;
            1: return k <= 4 ? 400 : 200;
            2: return 450 - 15 * k;
            default: return 500;
        endcase
    endfunction

    // phase accumulator: exactly model() single-cycle pulses in any 1024 cycles
    initial begin
        logic [10:0] s;
        logic [9:0] acc;
        acc = '0;
        forever begin
            @(posedge clk);
            #1;
            s = {1'b0, acc} + 11'(model($countones(trim)));
            acc = s[9:0];
            osc_div_sync = s[10];
        end
    end

    always @(negedge clk) begin
        if (resetn && done) begin
            dones++;
            if (exp_q.size() == 0) chk("unexpected_done", 32'(exp_q.size()), 1);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_code", 32'(code), 32'(e.code));
                chk("done_locked", 32'(locked), 32'(e.lk));
                chk("done_err", 32'(err), 32'(e.er));
                chk("done_trim", 32'(trim), 32'(e.trim));
                chk("done_busy", 32'(busy), 0);
                if (e.lat != 0) chk("done_latency", 32'(cyc - st_cyc), 32'(e.lat));
            end
        end
    end

    task automatic run(int md, int tg, int tl, logic [4:0] ec, logic el, logic ee,
                       logic [25:0] et, int lat, bit dbl);
        exp_t e;
        int d0, n;
        mode = md;
        target = 16'(tg);
        tol = 16'(tl);
        e = '{ec, el, ee, et, lat};
        exp_q.push_back(e);
        d0 = dones;
        @(posedge clk); #1 start = 1; st_cyc = cyc;
        @(posedge clk); #1 start = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("osc_reset_after_start", 32'(osc_reset), 1);
        if (dbl) begin
            repeat (100) @(posedge clk);
            #1 start = 1;
            @(posedge clk); #1 start = 0;
        end
        n = 0;
        while (dones == d0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        chk("done_seen", 32'(dones - d0), 1);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int d0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_code", 32'(code), 0);
        chk("rst_trim", 32'(trim), 0);
        chk("rst_osc_reset", 32'(osc_reset), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        resetn = 1;
        repeat (3) @(posedge clk);
        #1;
        run(0, 500, 10, 5'd0, 1, 0, 26'h0, 1050, 0);
        run(1, 300, 10, 5'd5, 1, 0, 26'h1F, 0, 0);
        run(2, 300, 7, 5'd10, 1, 0, 26'h3FF, 0, 0);
        run(2, 150, 7, 5'd20, 1, 0, 26'hFFFFF, 0, 0);
        chk("sec_trim_low", 32'(trim[12:0]), 32'h1FFF);
        chk("sec_trim_high", 32'(trim[19:13]), 32'h7F);
        run(3, 100, 5, 5'd26, 0, 1, 26'h3FFFFFF, 0, 0);
        repeat (50) @(posedge clk);
        #1 chk("err_sticky", 32'(err), 1);
        mode = 0; target = 500; tol = 10;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (200) @(posedge clk);
        #1 enable = 0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_osc_reset", 32'(osc_reset), 1);
        chk("abort_locked", 32'(locked), 0);
        chk("abort_code", 32'(code), 26);
        chk("abort_err", 32'(err), 0);
        d0 = dones;
        repeat (1200) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(dones - d0), 0);
        chk("disabled_osc_reset", 32'(osc_reset), 1);
        enable = 1;
        run(0, 500, 10, 5'd26, 1, 0, 26'h3FFFFFF, 1050, 1);
        manual_en = 1;
        manual_code = 5'd31;
        repeat (2) @(posedge clk);
        #1;
        chk("manual_clamp_code", 32'(code), 26);
        chk("manual_clamp_trim", 32'(trim), 32'h3FFFFFF);
        chk("manual_osc_reset", 32'(osc_reset), 0);
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        chk("manual_start_ignored", 32'(busy), 0);
        manual_code = 5'd7;
        @(posedge clk); #1;
        chk("manual_code7", 32'(code), 7);
        chk("manual_trim7", 32'(trim), 32'h7F);
        manual_en = 0;
        mode = 2; target = 150; tol = 7;
        @(posedge clk); #1 start = 1;
        @(posedge clk); #1 start = 0;
        repeat (300) @(posedge clk);
        #1 resetn = 0;
        #1;
        chk("midrst_code", 32'(code), 0);
        chk("midrst_trim", 32'(trim), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_osc_reset", 32'(osc_reset), 1);
        chk("midrst_locked", 32'(locked), 0);
        repeat (2) @(posedge clk);
        #1 resetn = 1;
        repeat (5) @(posedge clk);
        #1;
        chk("queue_drained", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule

// File: doc/ring_osc_trim_ctrl.md
# ring_osc_trim_ctrl

Closed-loop trim controller for the 13-stage trimmable ring oscillator (26-bit trim, 13 primary + 13 secondary bits). It holds the oscillator in reset, releases it, measures its frequency against the system clock, and steps a thermometer trim code until the measured count is within tolerance of a programmed target. It sits in the clocking block between the housekeeping registers and the oscillator's `reset` / `trim` inputs.

## Interface
- `WINDOW`, 1024: measurement window length in `clk` cycles.
- `SETTLE`, 16: `clk` cycles waited after any trim change or oscillator release before measuring.
- `RST_CYCLES`, 8: `clk` cycles the oscillator reset is held at start.
- `CNT_W`, 16: width of edge counter, target and tolerance.
- `MAX_ITER`, 32: maximum measure/adjust iterations per run.

- `clk` in 1: system reference clock.
- `resetn` in 1: asynchronous, active-low reset.
- `enable` in 1: controller enable; low aborts and parks.
- `start` in 1: single-cycle pulse that begins calibration.
- `osc_div_sync` in 1: oscillator output divided externally and 2-flop synchronized into `clk`.
- `target` in CNT_W: desired rising-edge count of `osc_div_sync` per window.
- `tol` in CNT_W: allowed deviation.
- `manual_en` in 1: bypass loop and drive `manual_code`.
- `manual_code` in 5: trim code 0..26 used when `manual_en`=1.
- `trim` out 26: oscillator trim vector.
- `osc_reset` out 1: oscillator reset, active high.
- `busy` out 1: calibration in progress.
- `locked` out 1: last run converged.
- `done` out 1: one-cycle pulse at the end of a run (lock or error).
- `err` out 1: last run failed; sticky until the next `start`.
- `code` out 5: current trim code.

## Operation
- Code to trim, for code k (0..26): k≤13 sets `trim[k-1:0]` and clears the rest. k>13 sets `trim[12:0]` and `trim[13+k-14:13]`. Code 26 is all ones. A higher code gives a slower oscillator.
- `manual_en`=1 in IDLE: `code`=min(`manual_code`,26) each cycle. `osc_reset`=0. `start` is ignored.
- FSM states:
  - IDLE: waits for `start`&`enable`&!`manual_en`. Then it clears `err`/`locked`, sets `busy`, clears the iteration counter, and goes to ORST.
  - ORST: `osc_reset`=1 for RST_CYCLES, then SETTLE.
  - SETTLE: `osc_reset`=0. Waits SETTLE cycles, then MEASURE.
  - MEASURE: counts rising edges (`osc_div_sync` & ~previous sample; the previous-sample register updates every cycle) for exactly WINDOW cycles. The count saturates at 2^CNT_W−1. Then COMPARE.
  - COMPARE, single cycle, using CNT_W+1-bit arithmetic with `target`−`tol` floored at 0:
    - count > target+tol: step +1.
    - count < target−tol: step −1.
    - Otherwise: lock.
    - Step +1 at code 26, or step −1 at code 0: error.
    - Step direction opposite to the previous step in this run: lock at the current code (dither guard).
    - Iteration counter reaching MAX_ITER: error.
    - Otherwise apply the step, increment the iteration counter, and go to SETTLE.
  - FINISH: pulses `done`, clears `busy`, sets `locked` or `err`, then IDLE. On error, `code` holds its last value.
- A new run starts from the current `code`, not 0. The first run after reset starts from 0.
- `start` while `busy` is ignored.
- `enable` low in any state other than IDLE: next cycle goes to IDLE with `osc_reset`=1, `busy`=0, `locked`=0, no `done`, and `code` held. `osc_reset` stays 1 while `enable`=0 and `manual_en`=0.

## Timing
- Reset values: `trim`=0, `code`=0, `osc_reset`=1, `busy`=0, `locked`=0, `done`=0, `err`=0, FSM=IDLE.
- All outputs are registered. `trim` is a registered decode of the next `code`, so it changes in the same cycle as `code`.
- `start` sampled in cycle t: `busy`=1 and `osc_reset`=1 from t+1.
- First iteration length is RST_CYCLES+SETTLE+WINDOW+1 cycles. Each later iteration is SETTLE+WINDOW+1.
- `done` asserts the cycle after COMPARE decides, concurrent with the final `locked`/`err` value.
- Asserting `resetn` mid-run returns immediately to the reset values.

## Test plan
- Lock at start: target=500, tol=10, model gives 505 edges at code 0 → one iteration, `code`=0, `locked`=1, `done` pulse at cycle 8+16+1024+2 after `start`.
- Stepping: the model gives edges 900−30·code, target=600, tol=15 → `code` steps 0..10, locks at code 10 (count 600), `trim`=26'h00003FF.
- Secondary range: the model requires code 20 → `trim`=26'h007FFFF plus bits 19..13, i.e. 26'h00FFFFF… checked via the decode rule (`trim[12:0]` all ones, `trim[19:13]` all ones).
- Error: count stays above target at every code → reaches code 26, next COMPARE sets `err`=1, `locked`=0, `code`=26.
- Dither: count at code 4 is above the band and count at code 5 is below it → steps to 5, reverses, locks at 5.
- Abort: drop `enable` mid-MEASURE → next cycle `busy`=0 and `osc_reset`=1 with no `done` pulse. Also: `start` during `busy` has no effect, and `manual_en` with `manual_code`=31 gives `code`=26.
